// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Writer side of the instruction memory. A byte stream (valid/ready) carries
//   a frame: LEN_HI, LEN_LO (16-bit word count N), then 4*N data bytes, MSB
//   first. Each assembled big-endian word is written to consecutive word
//   addresses starting at BASE_ADDR. cpu_hold keeps the core in reset until
//   the load completes.
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
//   checksum byte (state CSUM) that must match before the core is released.
module imem_stream_loader #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 256,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6,
    S_CSUM   = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;
`endif

  // Largest accepted word count, widened so N (16 bits) compares without truncation.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(3'd4);

  state_t              state_r, state_next_s;
  logic [15:0]         len_r;
  logic [15:0]         word_cnt_r;
  logic [1:0]          byte_cnt_r;
  logic [23:0]         word_r;
  logic [ADDR_W-1:0]   imem_addr_r;
  logic [31:0]         imem_wdata_r;
  logic                in_ready_r, imem_we_r, cpu_hold_r, done_r, error_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_r;
`endif

  logic                accept_s;
  logic                restart_s;
  logic                last_word_s;
  logic [15:0]         len_full_s;
  logic                in_ready_next_s, imem_we_next_s, cpu_hold_next_s;
  logic                done_next_s, error_next_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of all data bytes.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    csum_update = acc ^ b;
  endfunction
`endif

  assign accept_s    = in_valid && in_ready_r;
  assign len_full_s  = {len_r[15:8], in_data};
  assign last_word_s = (word_cnt_r == (len_r - 16'd1));

  // Next-state decode plus the output levels implied by the next state.
  always_comb begin
    state_next_s    = state_r;
    restart_s       = 1'b0;
    in_ready_next_s = 1'b0;
    imem_we_next_s  = 1'b0;
    cpu_hold_next_s = 1'b1;
    done_next_s     = 1'b0;
    error_next_s    = 1'b0;

    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next_s = S_LEN_HI;
          restart_s    = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      S_LEN_HI: begin
        if (accept_s) state_next_s = S_LEN_LO;
        else          state_next_s = state_r;
      end
      S_LEN_LO: begin
        if (accept_s) begin
          if ((len_full_s == 16'd0) || ({1'b0, len_full_s} > DEPTH_W)) state_next_s = S_ERR;
          else                                                        state_next_s = S_DATA;
        end else begin
          state_next_s = state_r;
        end
      end
      S_DATA: begin
        if (accept_s && (byte_cnt_r == 2'd3)) state_next_s = S_WRITE;
        else                                  state_next_s = state_r;
      end
      S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (last_word_s) state_next_s = S_CSUM;
`else
        if (last_word_s) state_next_s = S_DONE;
`endif
        else             state_next_s = S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept_s) begin
          if (in_data == csum_r) state_next_s = S_DONE;
          else                   state_next_s = S_ERR;
        end else begin
          state_next_s = state_r;
        end
      end
`endif
      default: state_next_s = S_IDLE;
    endcase

    case (state_next_s)
      S_LEN_HI, S_LEN_LO, S_DATA: in_ready_next_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                     in_ready_next_s = 1'b1;
`endif
      S_WRITE:                    imem_we_next_s  = 1'b1;
      S_DONE: begin
        done_next_s     = 1'b1;
        cpu_hold_next_s = 1'b0;
      end
      S_ERR:                      error_next_s    = 1'b1;
      default: begin
        in_ready_next_s = 1'b0;
      end
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b0;
      imem_we_r  <= 1'b0;
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= in_ready_next_s;
      imem_we_r  <= imem_we_next_s;
      cpu_hold_r <= cpu_hold_next_s;
      done_r     <= done_next_s;
      error_r    <= error_next_s;
    end
  end

  // Length capture, word assembly, counters and write address.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      len_r        <= 16'd0;
      word_cnt_r   <= 16'd0;
      byte_cnt_r   <= 2'd0;
      word_r       <= 24'd0;
      imem_addr_r  <= BASE_ADDR;
      imem_wdata_r <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else if (restart_s) begin
      len_r       <= 16'd0;
      word_cnt_r  <= 16'd0;
      byte_cnt_r  <= 2'd0;
      word_r      <= 24'd0;
      imem_addr_r <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      case (state_r)
        S_LEN_HI: if (accept_s) len_r[15:8] <= in_data;
        S_LEN_LO: if (accept_s) len_r[7:0]  <= in_data;
        S_DATA: begin
          if (accept_s) begin
            word_r     <= {word_r[15:0], in_data};
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r     <= csum_update(csum_r, in_data);
`endif
            if (byte_cnt_r == 2'd3) imem_wdata_r <= {word_r, in_data};
          end
        end
        S_WRITE: begin
          // The address stays on the last written word once the frame ends.
          if (!last_word_s) begin
            word_cnt_r  <= word_cnt_r + 16'd1;
            imem_addr_r <= imem_addr_r + ADDR_STEP;
          end
        end
        default: begin
          word_cnt_r <= word_cnt_r;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule
